// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: 32-bit word reads split into 16-bit instructions
// through a small prefetch queue, with branch redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [9:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [15:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  // Halfword-granular PCs: bit 0 of every byte address is always zero.
  logic [31:1]   fetch_pc;
  logic [31:1]   issue_pc;
  logic          in_flight;

  logic [15:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [15:0]   hold_instr;
  logic [31:0]   hold_pc;

  logic          deq;
  logic          push_en;
  logic          push_one;
  logic [1:0]    npush;
  logic [SW-1:0] need;
  logic [SW-1:0] avail;
  logic [31:0]   word_base;
  logic          unused_bits;

  assign unused_bits = redirect_pc[0];

  assign instr_valid = (count != '0);
  assign deq         = instr_valid & instr_ready;

  // A request reserves two slots; data already in flight still owns its two.
  assign need    = SW'(count) + SW'({in_flight, 1'b0}) + SW'(2);
  assign avail   = SW'(QDEPTH) + SW'(deq);
  assign mem_req = ~reset & ~redirect & (need <= avail);

  assign mem_addr  = fetch_pc[11:2];
  assign word_base = {issue_pc[31:2], 2'b00};

  // A word fetched at an odd halfword only contributes its upper half.
  assign push_en  = in_flight & ~redirect;
  assign push_one = issue_pc[1];
  assign npush    = push_en ? (push_one ? 2'd1 : 2'd2) : 2'd0;

  assign instr    = instr_valid ? q_instr[rd_ptr] : hold_instr;
  assign instr_pc = instr_valid ? q_pc[rd_ptr]    : hold_pc;

  always_ff @(posedge clock) begin
    if (push_en) begin
      if (push_one) begin
        q_instr[wr_ptr] <= mem_rdata[31:16];
        q_pc[wr_ptr]    <= word_base + 32'd2;
      end else begin
        q_instr[wr_ptr]           <= mem_rdata[15:0];
        q_pc[wr_ptr]              <= word_base;
        q_instr[wr_ptr + AW'(1)]  <= mem_rdata[31:16];
        q_pc[wr_ptr + AW'(1)]     <= word_base + 32'd2;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC[31:1];
      issue_pc   <= '0;
      in_flight  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      // Remember what was last presented so an empty queue keeps showing it.
      if (instr_valid) begin
        hold_instr <= q_instr[rd_ptr];
        hold_pc    <= q_pc[rd_ptr];
      end
      if (redirect) begin
        fetch_pc  <= redirect_pc[31:1];
        in_flight <= 1'b0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
      end else begin
        in_flight <= mem_req;
        if (mem_req) begin
          issue_pc <= fetch_pc;
          fetch_pc <= {fetch_pc[31:2] + 30'd1, 1'b0};
        end
        rd_ptr <= rd_ptr + AW'(deq);
        wr_ptr <= wr_ptr + AW'(npush);
        count  <= count + CW'(npush) - CW'(deq);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [9:0] w);
    if (w == 10'd0) return 32'h2205_2103;
    return {6'b101000, w, 6'b010100, w};
  endfunction

  function automatic logic [15:0] exp_instr(input logic [31:0] pc);
    logic [31:0] wd;
    wd = memword(pc[11:2]);
    return pc[1] ? wd[31:16] : wd[15:0];
  endfunction

  always @(posedge clock) begin
    if (mem_req) mem_rdata <= memword(mem_addr);
  end

  task automatic do_reset(input logic ready);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = ready;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic consume(input logic [31:0] start, input int n, input bit nobub, input string tag);
    logic [31:0] pc;
    int got;
    int waited;
    pc = start;
    got = 0;
    waited = 0;
    while (got < n && waited < 64) begin
      if (nobub && got > 0) begin
        checks++;
        if (instr_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s bubble: instr_valid=%b required 1 at pc %h", tag, instr_valid, pc);
        end
      end
      if (instr_valid) begin
        checks++;
        if (instr !== exp_instr(pc) || instr_pc !== pc) begin
          errors++;
          $display("FAIL %s data: instr=%h pc=%h required instr=%h pc=%h",
                   tag, instr, instr_pc, exp_instr(pc), pc);
        end
        pc = pc + 32'd2;
        got++;
      end
      waited++;
      @(negedge clock);
      #1;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s timeout: got %0d instrs required %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 10'd0 ||
        instr !== 16'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b addr=%h instr=%h pc=%h required 0 0 0 0 0",
               mem_req, instr_valid, mem_addr, instr, instr_pc);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1 000", mem_req, mem_addr);
    end
    @(negedge clock); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: instr_valid=%b required 0", instr_valid);
    end
    @(negedge clock); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h2103 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL first_instr: valid=%b instr=%h pc=%h required 1 2103 0", instr_valid, instr, instr_pc);
    end
    consume(32'h0, 20, 1'b1, "stream");
  endtask

  task automatic test_backpressure();
    int reqs;
    do_reset(1'b0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) reqs++;
      @(negedge clock); #1;
    end
    checks++;
    if (reqs !== 2 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_requests: reqs=%0d req_now=%b required 2 0", reqs, mem_req);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h2103 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b instr=%h pc=%h required 1 2103 0", instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    #1;
    consume(32'h0, 16, 1'b0, "bp_release");
  endtask

  task automatic test_redirect();
    int budget;
    do_reset(1'b1);
    consume(32'h0, 6, 1'b0, "pre_redirect");
    budget = 0;
    while (!mem_req && budget < 20) begin
      @(negedge clock); #1;
      budget++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect_find_req: req=%b required 1", mem_req);
    end
    @(negedge clock);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0106;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_noreq: req=%b required 0", mem_req);
    end
    @(negedge clock);
    redirect = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'd65) begin
      errors++;
      $display("FAIL redirect_flush: valid=%b req=%b addr=%0d required 0 1 65", instr_valid, mem_req, mem_addr);
    end
    consume(32'h0000_0106, 6, 1'b0, "redirect");
  endtask

  task automatic test_wrap();
    @(negedge clock);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0FFC;
    #1;
    @(negedge clock);
    redirect = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_addr_hi: req=%b addr=%h required 1 3ff", mem_req, mem_addr);
    end
    @(negedge clock); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_addr_lo: req=%b addr=%h valid=%b required 1 000 0", mem_req, mem_addr, instr_valid);
    end
    consume(32'h0000_0FFC, 6, 1'b0, "wrap");
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
    end
    #1;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fill: valid=%b required 1", instr_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instr !== 16'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b req=%b instr=%h pc=%h required 0 0 0 0",
               instr_valid, mem_req, instr, instr_pc);
    end
    @(negedge clock);
    reset       = 1'b0;
    instr_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL midreset_restart: req=%b addr=%h required 1 000", mem_req, mem_addr);
    end
    consume(32'h0, 8, 1'b0, "midreset");
  endtask

  initial begin
    mem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 required finished");
    $fatal(1, "timeout");
  end

endmodule
